// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execute stage: ALUControl op codes, FSM states
// and the ALUControl width.
package alu_pkg;

  localparam int ALU_CTRL_W = 3;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shifter for the ALU execute stage: one bit per cycle by default, or a
// single-cycle barrel shifter when ALU_EXEC_FAST_SHIFT_EN is defined.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             last
);

`ifdef ALU_EXEC_FAST_SHIFT_EN

  logic [WIDTH:0] left_ext;
  logic [WIDTH:0] right_ext;
  logic           unused_seq;

  assign unused_seq = ^{clk, rst, load};
  assign last       = 1'b0;

  // One guard bit beyond each end catches the last bit shifted out (0 for shamt==0).
  always_comb begin
    left_ext  = {1'b0, a} << shamt;
    right_ext = {a, 1'b0} >> shamt;
    if (op == ALU_SRA) begin
      right_ext = $signed({a, 1'b0}) >>> shamt;
    end
    if (op == ALU_SLL) begin
      value = left_ext[WIDTH-1:0];
      carry = left_ext[WIDTH];
    end else begin
      value = right_ext[WIDTH:1];
      carry = right_ext[0];
    end
  end

`else

  logic [WIDTH-1:0] shreg;
  logic [SHW-1:0]   cnt;
  alu_op_e          op_q;

  // value/carry are the outcome of the shift that happens at the next edge.
  always_comb begin
    value = {shreg[WIDTH-2:0], 1'b0};
    carry = shreg[WIDTH-1];
    if (op_q == ALU_SRL) begin
      value = {1'b0, shreg[WIDTH-1:1]};
      carry = shreg[0];
    end else if (op_q == ALU_SRA) begin
      value = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
      carry = shreg[0];
    end
  end

  assign last = (cnt == SHW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      op_q  <= ALU_SLL;
    end else if (load) begin
      shreg <= a;
      cnt   <= shamt;
      op_q  <= op;
    end else if (cnt != '0) begin
      shreg <= value;
      cnt   <= cnt - SHW'(1);
    end
  end

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: registered result and NZCV flags behind a valid/ready
// handshake. Shifts are iterative unless ALU_EXEC_FAST_SHIFT_EN is defined.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] ALUControl,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  negative,
  output logic                  carry,
  output logic                  overflow,
  output logic                  busy
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  alu_op_e          op;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             start_shift;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [WIDTH-1:0] comb_res;
  logic             comb_carry;
  logic             comb_ovf;
  logic [WIDTH-1:0] sh_value;
  logic             sh_carry;
  logic             sh_last;

  assign op       = alu_op_e'(ALUControl);
  assign shamt    = src_b[SHW-1:0];
  assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign start_shift = 1'b0;
  assign busy        = 1'b0;
`else
  assign start_shift = accept && is_shift(op) && (shamt != '0);
  assign busy        = (state == ST_SHIFT);
`endif

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (start_shift),
    .op    (op),
    .a     (src_a),
    .shamt (shamt),
    .value (sh_value),
    .carry (sh_carry),
    .last  (sh_last)
  );

  // SUB and SLT share a + ~b + 1, so carry-out set means "no borrow".
  assign is_sub  = (op == ALU_SUB) || (op == ALU_SLT);
  assign b_eff   = is_sub ? ~src_b : src_b;
  assign sum     = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign add_ovf = (src_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);

  always_comb begin
    comb_res   = sum[WIDTH-1:0];
    comb_carry = 1'b0;
    comb_ovf   = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        comb_carry = sum[WIDTH];
        comb_ovf   = add_ovf;
      end
      ALU_AND: comb_res = src_a & src_b;
      ALU_OR:  comb_res = src_a | src_b;
      ALU_SLT: comb_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
        comb_res   = sh_value;
        comb_carry = sh_carry;
`else
        comb_res   = src_a;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (sh_last) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            result    <= sh_value;
            zero      <= (sh_value == '0);
            negative  <= sh_value[WIDTH-1];
            carry     <= sh_carry;
            overflow  <= 1'b0;
          end
        end
        default: begin
          if (start_shift) begin
            state     <= ST_SHIFT;
            out_valid <= 1'b0;
          end else if (accept) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            result    <= comb_res;
            zero      <= (comb_res == '0);
            negative  <= comb_res[WIDTH-1];
            carry     <= comb_carry;
            overflow  <= comb_ovf;
          end else if ((state == ST_HOLD) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random traffic
// compared every cycle against a behavioural model. Honours ALU_EXEC_FAST_SHIFT_EN.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   ALUControl = 3'b000;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, negative, carry, overflow, busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ready_mode = 1;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;
    int           acc;
    int           lat;
  } txn_t;

  txn_t q[$];

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .negative   (negative),
    .carry      (carry),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Latency here counts clock edges after the accepting edge before out_valid shows.
  function automatic int lat_of(input logic [2:0] op, input logic [W-1:0] b);
`ifdef ALU_EXEC_FAST_SHIFT_EN
    return 0;
`else
    if (op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) return int'(b[4:0]);
    return 0;
`endif
  endfunction

  function automatic txn_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    txn_t         t;
    longint       sa, sb, sr;
    int           s;
    logic         c, v;
    logic [W-1:0] r;
    sa = $signed(a);
    sb = $signed(b);
    sr = 0;
    s  = int'(b[4:0]);
    c  = 1'b0;
    v  = 1'b0;
    r  = '0;
    case (op)
      ALU_ADD: begin
        r  = a + b;
        sr = sa + sb;
        c  = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        v  = (sr != longint'($signed(r)));
      end
      ALU_SUB: begin
        r  = a - b;
        sr = sa - sb;
        c  = (a >= b);
        v  = (sr != longint'($signed(r)));
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLL: begin
        r = a << s;
        c = (s != 0) ? a[W-s] : 1'b0;
      end
      ALU_SRL: begin
        r = a >> s;
        c = (s != 0) ? a[s-1] : 1'b0;
      end
      default: begin
        r = $signed(a) >>> s;
        c = (s != 0) ? a[s-1] : 1'b0;
      end
    endcase
    t.res   = r;
    t.flags = {(r == '0), r[W-1], c, v};
    t.acc   = 0;
    t.lat   = lat_of(op, b);
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got;
    @(posedge clk);
    #1;
    ALUControl = op;
    src_a      = a;
    src_b      = b;
    in_valid   = 1'b1;
    got        = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL accept timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string name, input logic [W-1:0] exp_res,
                            input logic [3:0] exp_flags, input int exp_lat);
    int  start;
    bit  seen;
    start = cyc;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timeout: got out_valid=0 expected 1 within 100 cycles", name);
    end else begin
      checkOutput({name, " latency"}, 64'(cyc - start), 64'(exp_lat));
      checkOutput({name, " result"}, 64'(result), 64'(exp_res));
      checkOutput({name, " flags"}, 64'({zero, negative, carry, overflow}), 64'(exp_flags));
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Cycle-by-cycle comparison of handshake, busy and data against the model queue.
  always @(negedge clk) begin : monitor
    bit   exp_valid, exp_busy, exp_ready;
    txn_t t;
    if (rst) begin
      checkOutput("reset ctrl", 64'({out_valid, busy, zero, negative, carry, overflow}), 64'd0);
      checkOutput("reset result", 64'(result), 64'd0);
      q.delete();
    end else begin
      exp_valid = (q.size() > 0) && (cyc >= q[0].acc + q[0].lat);
      exp_busy  = (q.size() > 0) && !exp_valid;
      exp_ready = (q.size() == 0) || (exp_valid && out_ready);
      checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
      checkOutput("busy", 64'(busy), 64'(exp_busy));
      checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
      if (exp_valid) begin
        checkOutput("model result", 64'(result), 64'(q[0].res));
        checkOutput("model flags", 64'({zero, negative, carry, overflow}), 64'(q[0].flags));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
        t     = model(ALUControl, src_a, src_b);
        t.acc = cyc + 1;
        q.push_back(t);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 50000 cycles");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    txn_t         m;
    logic [2:0]   op;
    logic [W-1:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Hand-computed literals that pin the reference model itself.
    m = model(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
    checkOutput("pin add", 64'({m.res, m.flags}), 64'({32'h0, 4'b1010}));
    m = model(ALU_SUB, 32'h8000_0000, 32'h1);
    checkOutput("pin sub", 64'({m.res, m.flags}), 64'({32'h7FFF_FFFF, 4'b0011}));
    m = model(ALU_SLT, 32'h8000_0000, 32'h1);
    checkOutput("pin slt", 64'({m.res, m.flags}), 64'({32'h1, 4'b0000}));
    m = model(ALU_SRA, 32'h8000_0010, 32'd4);
    checkOutput("pin sra", 64'({m.res, m.flags}), 64'({32'hF800_0001, 4'b0100}));
    m = model(ALU_SLL, 32'h8000_0001, 32'd1);
    checkOutput("pin sll", 64'({m.res, m.flags}), 64'({32'h2, 4'b0010}));
    m = model(ALU_SUB, 32'd5, 32'd7);
    checkOutput("pin borrow", 64'({m.res, m.flags}), 64'({32'hFFFF_FFFE, 4'b0100}));

    ready_mode = 1;
    applyStimulus(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
    waitResult("add wrap", 32'h0, 4'b1010, 0);
    applyStimulus(ALU_SUB, 32'h8000_0000, 32'h1);
    waitResult("sub ovf", 32'h7FFF_FFFF, 4'b0011, 0);
    applyStimulus(ALU_SLT, 32'h8000_0000, 32'h1);
    waitResult("slt", 32'h1, 4'b0000, 0);
    applyStimulus(ALU_SRA, 32'h8000_0010, 32'd4);
    waitResult("sra4", 32'hF800_0001, 4'b0100, lat_of(ALU_SRA, 32'd4));
    applyStimulus(ALU_SLL, 32'h8000_0001, 32'd1);
    waitResult("sll1", 32'h2, 4'b0010, lat_of(ALU_SLL, 32'd1));

    // Backpressure: result must hold while the consumer stalls.
    ready_mode = 0;
    applyStimulus(ALU_ADD, 32'd3, 32'd4);
    waitResult("add hold", 32'd7, 4'b0000, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold result", 64'(result), 64'd7);
      checkOutput("hold in_ready", 64'(in_ready), 64'd0);
      checkOutput("hold out_valid", 64'(out_valid), 64'd1);
    end
    ready_mode = 1;
    applyStimulus(ALU_AND, 32'hF0, 32'h3C);
    waitResult("and b2b", 32'h30, 4'b0000, 0);

    // Reset in the middle of a long shift.
    applyStimulus(ALU_SRL, 32'hFFFF_0000, 32'd20);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midshift rst ctrl", 64'({out_valid, busy}), 64'd0);
    checkOutput("midshift rst result", 64'(result), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post rst in_ready", 64'(in_ready), 64'd1);
    applyStimulus(ALU_ADD, 32'd1, 32'd1);
    waitResult("add post rst", 32'd2, 4'b0000, 0);

    applyStimulus(ALU_SLL, 32'h1234, 32'd0);
    waitResult("sll0", 32'h1234, 4'b0000, 0);

    // Random traffic with random consumer stalls; the monitor does the checking.
    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'h8000_0000;
        2:       a = 32'hFFFF_FFFF;
        default: a = 32'($urandom_range(0, 40));
      endcase
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = 32'h7FFF_FFFF;
        2:       b = 32'($urandom_range(0, 31));
        default: b = a;
      endcase
      applyStimulus(op, a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    ready_mode = 1;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", q.size());
    end
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
